// File: rtl/if_pkg.sv
// Shared defaults and the next-PC select encoding for the instruction-fetch stage.
package if_pkg;

    localparam int          DEF_XLEN     = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_PC_STEP  = 32'd4;

    // Which source the next fetch PC comes from, listed in priority order.
    typedef enum logic [1:0] {
        SEL_FLUSH = 2'd0,
        SEL_HOLD  = 2'd1,
        SEL_PRED  = 2'd2,
        SEL_SEQ   = 2'd3
    } pc_sel_t;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC priority encoder and mux: flush > stall > predicted taken > sequential.
// With IF_ALIGN_EN defined, loaded targets have bits[1:0] cleared and a
// misaligned-load indication is produced alongside next_pc.
module pc_next_mux
    import if_pkg::*;
#(
    parameter int              XLEN    = DEF_XLEN,
    parameter logic [XLEN-1:0] PC_STEP = XLEN'(DEF_PC_STEP)
) (
    input  logic [XLEN-1:0] cpc,
    input  logic [XLEN-1:0] pc_branch,
    input  logic [XLEN-1:0] control_pc,
    input  logic            flush,
    input  logic            nop,
    input  logic            prediction,
`ifdef IF_ALIGN_EN
    output logic            load_misaligned,
`endif
    output logic [XLEN-1:0] next_pc,
    output pc_sel_t         sel
);

`ifdef IF_ALIGN_EN
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
`endif

    // Fixed-priority selection of the next PC source.
    always_comb begin
        sel = SEL_SEQ;
        if (flush) begin
            sel = SEL_FLUSH;
        end else if (nop) begin
            sel = SEL_HOLD;
        end else if (prediction) begin
            sel = SEL_PRED;
        end
    end

    // Route the selected source; sequential addition wraps modulo 2^XLEN.
    always_comb begin
        next_pc = cpc + PC_STEP;
`ifdef IF_ALIGN_EN
        load_misaligned = 1'b0;
`endif
        case (sel)
`ifdef IF_ALIGN_EN
            SEL_FLUSH: begin
                next_pc         = control_pc & ALIGN_MASK;
                load_misaligned = |control_pc[1:0];
            end
            SEL_PRED: begin
                next_pc         = pc_branch & ALIGN_MASK;
                load_misaligned = |pc_branch[1:0];
            end
`else
            SEL_FLUSH: next_pc = control_pc;
            SEL_PRED:  next_pc = pc_branch;
`endif
            SEL_HOLD:  next_pc = cpc;
            default:   next_pc = cpc + PC_STEP;
        endcase
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch PC register. Holds cpc and loads the next PC chosen by
// pc_next_mux on every rising edge; rst is asynchronous, active-low.
// Optional feature macro: IF_ALIGN_EN (clears target bits[1:0] and adds the
// registered misalign output). sel is exported for observability.
module if_stage
    import if_pkg::*;
#(
    parameter int              XLEN     = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC),
    parameter logic [XLEN-1:0] PC_STEP  = XLEN'(DEF_PC_STEP)
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] cpc,
    input  logic [XLEN-1:0] pc_branch,
    input  logic            NOP,
    input  logic            flush,
    input  logic            prediction,
    input  logic [XLEN-1:0] control_pc,
`ifdef IF_ALIGN_EN
    output logic            misalign,
`endif
    output pc_sel_t         sel
);

    logic [XLEN-1:0] next_pc;
`ifdef IF_ALIGN_EN
    logic            load_misaligned;
`endif

    pc_next_mux #(
        .XLEN    (XLEN),
        .PC_STEP (PC_STEP)
    ) u_pc_next_mux (
        .cpc             (cpc),
        .pc_branch       (pc_branch),
        .control_pc      (control_pc),
        .flush           (flush),
        .nop             (NOP),
        .prediction      (prediction),
`ifdef IF_ALIGN_EN
        .load_misaligned (load_misaligned),
`endif
        .next_pc         (next_pc),
        .sel             (sel)
    );

    // Fetch PC register: forced to RESET_PC while rst is low, else loads next_pc.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpc <= RESET_PC;
        end else begin
            cpc <= next_pc;
        end
    end

`ifdef IF_ALIGN_EN
    // Misalign flag: high for the one cycle following a load of an unaligned target.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign <= 1'b0;
        end else begin
            misalign <= load_misaligned;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: reset behaviour, a directed vector table,
// mid-cycle reset assert/release, wraparound, optional alignment cases
// (IF_ALIGN_EN) and a randomized phase checked against a reference model.
module tb_if_stage;
    import if_pkg::*;

    localparam int W = 33;  // {misalign, cpc}

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] cpc;
    logic [31:0] pc_branch = '0;
    logic        nop = 1'b0;
    logic        flush = 1'b0;
    logic        prediction = 1'b0;
    logic [31:0] control_pc = '0;
    pc_sel_t     sel;
`ifdef IF_ALIGN_EN
    logic        misalign;
`endif

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] model_pc;

    typedef struct {
        logic        f;
        logic        n;
        logic        p;
        logic [31:0] pb;
        logic [31:0] cp;
        logic [31:0] exp_pc;
        pc_sel_t     exp_sel;
    } vec_t;

    vec_t tbl[13];

    if_stage dut (
        .clk        (clk),
        .rst        (rst),
        .cpc        (cpc),
        .pc_branch  (pc_branch),
        .NOP        (nop),
        .flush      (flush),
        .prediction (prediction),
        .control_pc (control_pc),
`ifdef IF_ALIGN_EN
        .misalign   (misalign),
`endif
        .sel        (sel)
    );

    // Clock: period 10, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference next-PC model built from the stated priority rules.
    function automatic logic [32:0] model_next(input logic [31:0] cur, input logic f, n, p,
                                               input logic [31:0] pb, cp);
        logic [31:0] tgt;
        logic        mis;
        mis = 1'b0;
        if (f)      tgt = cp;
        else if (n) return {1'b0, cur};
        else if (p) tgt = pb;
        else        return {1'b0, cur + 32'd4};
`ifdef IF_ALIGN_EN
        mis = (tgt[1:0] != 2'b00);
        tgt = {tgt[31:2], 2'b00};
`endif
        return {mis, tgt};
    endfunction

    // Drive one cycle of controls at the negedge, glitch them mid-cycle,
    // then compare the registered result just after the rising edge.
    task automatic step(input logic f, n, p, input logic [31:0] pb, cp,
                        input logic [W-1:0] exp, input pc_sel_t exp_sel, input string name);
        logic [W-1:0] got;
        @(negedge clk);
        flush = f; nop = n; prediction = p; pc_branch = pb; control_pc = cp;
        exp_q.push_back(exp);
        #1;
        check({name, "_sel"}, 32'(sel), 32'(exp_sel));
        // Glitch well away from the edge; only edge-sampled values matter.
        flush = ~f; nop = ~n; prediction = ~p;
        #1;
        flush = f; nop = n; prediction = p;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s: scoreboard queue empty", name);
        end else begin
            got = exp_q.pop_front();
            check({name, "_cpc"}, cpc, got[31:0]);
`ifdef IF_ALIGN_EN
            check({name, "_misalign"}, {31'b0, misalign}, {31'b0, got[32]});
`endif
        end
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'd0,   32'd0,   32'd4,   SEL_SEQ};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'd0,   32'd0,   32'd8,   SEL_SEQ};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'd0,   32'd0,   32'd12,  SEL_SEQ};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 32'd100, 32'd0,   32'd100, SEL_PRED};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'd100, 32'd0,   32'd104, SEL_SEQ};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'd100, 32'd0,   32'd108, SEL_SEQ};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 32'd100, 32'd0,   32'd108, SEL_HOLD};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 32'd100, 32'd0,   32'd108, SEL_HOLD};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'd50,  32'd200, 32'd200, SEL_FLUSH};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 32'd50,  32'd200, 32'd200, SEL_FLUSH};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 32'd50,  32'd200, 32'd204, SEL_SEQ};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 32'd50,  32'd200, 32'd208, SEL_SEQ};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 32'd50,  32'd200, 32'd212, SEL_SEQ};

        // Reset asserted from time 0: cpc is RESET_PC before any edge.
        #2;
        check("reset_initial", cpc, 32'd0);
        // Controls active during reset must not move cpc across edges.
        flush = 1'b1; control_pc = 32'd300; prediction = 1'b1; pc_branch = 32'd400;
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", cpc, 32'd0);
        // Release away from the edge; first update on the following rising edge.
        #2;
        flush = 1'b0; prediction = 1'b0; rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].f, tbl[i].n, tbl[i].p, tbl[i].pb, tbl[i].cp,
                 {1'b0, tbl[i].exp_pc}, tbl[i].exp_sel, $sformatf("vec%0d", i));
        end

        // Mid-cycle reset assert: cpc clears without a clock edge.
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_mid", cpc, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd200, {1'b0, 32'd0}, SEL_FLUSH, "reset_hold_flush");
        // Release mid-cycle; next edge performs a normal sequential step.
        #2;
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, {1'b0, 32'd4}, SEL_SEQ, "post_release");

        // Wraparound at the top of the address space.
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'hFFFF_FFFC, {1'b0, 32'hFFFF_FFFC}, SEL_FLUSH, "wrap_load");
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, {1'b0, 32'd0}, SEL_SEQ, "wrap_seq");

`ifdef IF_ALIGN_EN
        step(1'b0, 1'b0, 1'b1, 32'd102, 32'd0, {1'b1, 32'd100}, SEL_PRED, "align_pred");
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, {1'b0, 32'd104}, SEL_SEQ, "align_seq");
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd203, {1'b1, 32'd200}, SEL_FLUSH, "align_flush");
        step(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, {1'b0, 32'd200}, SEL_HOLD, "align_hold");
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'hFFFF_FFFC, {1'b0, 32'hFFFF_FFFC}, SEL_FLUSH, "align_wrap_load");
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, {1'b0, 32'd0}, SEL_SEQ, "align_wrap_seq");
`endif

        // Randomized phase against the reference model.
        model_pc = cpc;
        for (int i = 0; i < 60; i++) begin
            logic        f, n, p;
            logic [31:0] pb, cp;
            logic [W-1:0] e;
            pc_sel_t     es;
            f  = ($urandom_range(0, 5) == 0);
            n  = ($urandom_range(0, 4) == 0);
            p  = ($urandom_range(0, 2) == 0);
            pb = $urandom();
            cp = $urandom();
            e  = model_next(model_pc, f, n, p, pb, cp);
            es = f ? SEL_FLUSH : (n ? SEL_HOLD : (p ? SEL_PRED : SEL_SEQ));
            model_pc = e[31:0];
            step(f, n, p, pb, cp, e, es, $sformatf("rand%0d", i));
        end

        if (exp_q.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
